// File: rtl/serial_tagger_pkg.sv
// Shared helpers for the windowed crossbar stages.
// Pure elaboration-time functions; no hardware of its own.
package serial_tagger_pkg;

    // Width needed to hold every count value from 0 up to max inclusive.
    function automatic int unsigned credit_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/data_i.sv
// In-order stream bundle: payload, byte keep, packet last, valid/ready handshake.
// No logic; carries whatever latency and backpressure the endpoints implement.
interface data_i #(
    parameter type data_t = logic [31:0]
);
    localparam int unsigned KEEP_W = ($bits(data_t) + 7) / 8;

    data_t             data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              valid;
    logic              ready;

    modport s (input data, keep, last, valid, output ready);
    modport m (output data, keep, last, valid, input ready);
endinterface

// File: rtl/tagged_i.sv
// Stream bundle with a per-beat serial tag, used on the crossbar side.
// No logic; carries whatever latency and backpressure the endpoints implement.
interface tagged_i #(
    parameter type         data_t       = logic [31:0],
    parameter int unsigned SERIAL_WIDTH = 2
);
    localparam int unsigned KEEP_W = ($bits(data_t) + 7) / 8;

    data_t                   data;
    logic [KEEP_W-1:0]       keep;
    logic                    last;
    logic [SERIAL_WIDTH-1:0] tag;
    logic                    valid;
    logic                    ready;

    modport m (output data, keep, last, tag, valid, input ready);
    modport s (input data, keep, last, tag, valid, output ready);
endinterface

// File: rtl/serial_tagger_credit_counter.sv
// Saturating 0..MAX occupancy counter with full/empty and a sticky underflow flag.
// Count updates one cycle after inc/dec; no backpressure, callers gate inc with full.
module serial_tagger_credit_counter
    import serial_tagger_pkg::*;
#(
    parameter  int unsigned MAX = 4,
    localparam int unsigned CW  = credit_width(MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          underflow_o
);

    logic [CW-1:0] count_q, count_d;
    logic          uf_q, uf_d;
    logic          dec_ok;

    // A return with nothing outstanding is dropped and only flagged.
    assign dec_ok = dec_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        uf_d    = uf_q;
        if (dec_i && (count_q == '0)) begin
            uf_d = 1'b1;
        end
        if (inc_i && !dec_ok && (count_q != CW'(MAX))) begin
            count_d = count_q + CW'(1);
        end else if (dec_ok && !inc_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            uf_q    <= uf_d;
        end
    end

    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(MAX));
    assign empty_o     = (count_q == '0);
    assign underflow_o = uf_q;

endmodule

// File: rtl/serial_tagger.sv
// Stamps each in-order beat with a consecutive serial tag inside a DEPTH-beat credit window.
// One register stage (1-cycle latency); in.ready drops on output stall or full window.
module serial_tagger
    import serial_tagger_pkg::*;
#(
    parameter type         data_t       = logic [31:0],
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SERIAL_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_i.s                      in,
    tagged_i.m                    out,
    input  logic                  credit_return,
    output logic [SERIAL_WIDTH:0] outstanding,
    output logic                  idle,
    output logic                  err_underflow
);

    localparam int unsigned KEEP_W = ($bits(data_t) + 7) / 8;

    typedef logic [SERIAL_WIDTH-1:0] serial_t;

    // The reorder stage indexes its window by tag, so the window must be exactly the tag space.
    if ((SERIAL_WIDTH < 1) || (DEPTH != (2 ** SERIAL_WIDTH))) begin : g_bad_depth
        $error("serial_tagger: DEPTH must equal 2**SERIAL_WIDTH with SERIAL_WIDTH >= 1");
    end

    logic              valid_q;
    serial_t           tag_cnt_q, tag_cnt_d;
    serial_t           tag_q;
    data_t             data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;
    logic              win_full, win_empty;
    logic              in_rdy;
    logic              accept;

    // Full window blocks input even with an empty output register; returns take effect next cycle.
    assign in_rdy    = (!valid_q || out.ready) && !win_full;
    assign in.ready  = in_rdy;
    assign accept    = in.valid && in_rdy;
    assign tag_cnt_d = accept ? (tag_cnt_q + serial_t'(1)) : tag_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            tag_cnt_q <= '0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
            if (accept) begin
                valid_q <= 1'b1;
            end else if (out.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q  <= tag_cnt_q;
            data_q <= in.data;
            keep_q <= in.keep;
            last_q <= in.last;
        end
    end

    assign out.valid = valid_q;
    assign out.tag   = tag_q;
    assign out.data  = data_q;
    assign out.keep  = keep_q;
    assign out.last  = last_q;

    serial_tagger_credit_counter #(
        .MAX (DEPTH)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (accept),
        .dec_i       (credit_return),
        .count_o     (outstanding),
        .full_o      (win_full),
        .empty_o     (win_empty),
        .underflow_o (err_underflow)
    );

    assign idle = win_empty && !valid_q;

endmodule
